// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a word-organised on-chip SRAM: zero-wait writes with byte lanes,
// one-wait-state reads, and the two-cycle ERROR response for bad size, alignment or range.
module ahb_sram_slave #(
    parameter int MEM_AW = 10,
    parameter int WIN_AW = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_RD_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state;

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW+1:0] addr_p1;
    logic [2:0]        size_p1;
    logic [MEM_AW-1:0] word_p1;
    logic [3:0]        lanes_p1;
    logic              accept;
    logic              accept_err;
    logic              decode_slot;
    logic              unused_bits;

    function automatic logic xfer_error(input logic [WIN_AW-1:0] a, input logic [2:0] size);
        logic misaligned;
        logic outside;
        misaligned = (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00);
        // Anything above the array but inside the window is rejected, never aliased.
        outside    = (a >> (MEM_AW + 2)) != '0;
        return (size > 3'd2) || misaligned || outside;
    endfunction

    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b0001 << off;
            3'd1:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // Address phase: decode and capture.
    assign accept      = hsel & hready_in & htrans[1];
    assign accept_err  = xfer_error(haddr[WIN_AW-1:0], hsize);
    assign decode_slot = (state != S_RD_WAIT) && (state != S_ERR1);
    assign unused_bits = ^{hburst, hprot, haddr};

    always_ff @(posedge hclk) begin
        if (accept && decode_slot) begin
            addr_p1 <= haddr[MEM_AW+1:0];
            size_p1 <= hsize;
        end
    end

    assign word_p1  = addr_p1[MEM_AW+1:2];
    assign lanes_p1 = byte_lanes(size_p1, addr_p1[1:0]);

    // Data phase: write commits at the edge leaving WRITE unless reset discards it.
    always_ff @(posedge hclk) begin
        if (state == S_WRITE && !hreset) begin
            for (int n = 0; n < 4; n++) begin
                if (lanes_p1[n]) begin
                    mem[word_p1][8*n +: 8] <= hwdata[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= S_IDLE;
            hready_out <= 1'b1;
            hresp      <= RESP_OKAY;
            hrdata     <= '0;
        end else begin
            case (state)
                S_RD_WAIT: begin
                    state      <= S_RD_DATA;
                    hready_out <= 1'b1;
                    hresp      <= RESP_OKAY;
                    hrdata     <= mem[word_p1];
                end
                S_ERR1: begin
                    state      <= S_ERR2;
                    hready_out <= 1'b1;
                    hresp      <= RESP_ERROR;
                end
                default: begin
                    if (!accept) begin
                        state      <= S_IDLE;
                        hready_out <= 1'b1;
                        hresp      <= RESP_OKAY;
                    end else if (accept_err) begin
                        state      <= S_ERR1;
                        hready_out <= 1'b0;
                        hresp      <= RESP_ERROR;
                    end else if (hwrite) begin
                        state      <= S_WRITE;
                        hready_out <= 1'b1;
                        hresp      <= RESP_OKAY;
                    end else begin
                        state      <= S_RD_WAIT;
                        hready_out <= 1'b0;
                        hresp      <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

endmodule
